// File: rtl/ahb_subordinate_sram_pkg.sv
// Shared AHB types, subordinate FSM states and byte-lane/LFSR helpers for ahb_subordinate_sram.
package ahb_subordinate_sram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } t_htrans;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'd0,
    HSIZE_HALF   = 3'd1,
    HSIZE_WORD   = 3'd2,
    HSIZE_DWORD  = 3'd3,
    HSIZE_4WORD  = 3'd4,
    HSIZE_8WORD  = 3'd5,
    HSIZE_16WORD = 3'd6,
    HSIZE_32WORD = 3'd7
  } t_hsize;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } t_hburst;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } t_hresp;

  typedef enum logic [2:0] {
    SUB_IDLE = 3'd0,
    SUB_WAIT = 3'd1,
    SUB_DATA = 3'd2,
    SUB_ERR1 = 3'd3,
    SUB_ERR2 = 3'd4
  } t_sub_state;

  // Little-endian byte enables for a bus of nbytes lanes (4 or 8); bit k = lane k.
  function automatic logic [7:0] byte_en(t_hsize size, logic [2:0] lsb, int unsigned nbytes);
    logic [15:0] mask;
    logic [2:0]  off;
    case (size)
      HSIZE_BYTE: mask = 16'h0001;
      HSIZE_HALF: mask = 16'h0003;
      HSIZE_WORD: mask = 16'h000F;
      default:    mask = 16'h00FF;
    endcase
    off  = (nbytes > 32'd4) ? lsb : {1'b0, lsb[1:0]};
    mask = mask << off;
    return mask[7:0];
  endfunction

  // Galois LFSR step, polynomial x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

endpackage

// File: rtl/ahb_subordinate_ram.sv
// Word-wide RAM: synchronous read with read enable, byte-enabled write, contents not reset.
module ahb_subordinate_ram #(
  parameter int unsigned DATA_WDT = 32,
  parameter int unsigned DEPTH    = 1024,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned NB      = DATA_WDT / 8
) (
  input  logic                clk,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_WDT-1:0] rdata,
  input  logic                we,
  input  logic [NB-1:0]       be,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_WDT-1:0] wdata
);

  logic [DATA_WDT-1:0] mem [DEPTH];

  // Read returns the pre-write contents when both ports hit the same word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_subordinate_sram.sv
// AHB subordinate backed by an internal RAM with wait states, byte writes, write-to-read
// forwarding and two-cycle ERROR. AHB_SUBORDINATE_RAND_WAIT_EN adds 0..3 LFSR-driven waits.
module ahb_subordinate_sram
  import ahb_subordinate_sram_pkg::*;
#(
  parameter int unsigned DATA_WDT    = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  t_htrans             i_htrans,
  input  logic                i_hwrite,
  input  t_hsize              i_hsize,
  input  t_hburst             i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output t_hresp              o_hresp
);

  localparam int unsigned NB        = DATA_WDT / 8;
  localparam int unsigned LSB       = $clog2(NB);
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CNT_W     = 5;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'(NB);

  t_sub_state          state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                hready_n;
  t_hresp              hresp_n;

  logic [31:0]         offset_c;
  logic                range_ok_c, size_ok_c, align_ok_c, legal_c;
  logic                accept_c, decide_c, take_c;
  logic [AW-1:0]       word_c;
  logic [NB-1:0]       be_c;
  logic [CNT_W-1:0]    waits_c;

  logic                wr_q, rd_q;
  logic [AW-1:0]       word_q;
  logic [NB-1:0]       be_q;

  logic                fwd_hit_c, fwd_q;
  logic [NB-1:0]       fwd_be_q;
  logic [DATA_WDT-1:0] fwd_data_q;

  logic                ram_re, ram_we;
  logic [DATA_WDT-1:0] ram_rdata, merged_c, hold_q;
  logic                rd_active_c;

  logic                unused_ok;
  assign unused_ok = ^{i_hburst};

  // Address-phase decode: range, size and alignment checks.
  assign offset_c   = i_haddr - BASE_ADDR;
  assign range_ok_c = {1'b0, offset_c} < MEM_BYTES;
  assign size_ok_c  = 32'(i_hsize) <= LSB;
  assign word_c     = offset_c[LSB +: AW];
  assign be_c       = NB'(byte_en(i_hsize, i_haddr[2:0], NB));

  always_comb begin
    align_ok_c = 1'b0;
    case (i_hsize)
      HSIZE_BYTE:  align_ok_c = 1'b1;
      HSIZE_HALF:  align_ok_c = ~i_haddr[0];
      HSIZE_WORD:  align_ok_c = (i_haddr[1:0] == 2'b00);
      HSIZE_DWORD: align_ok_c = (i_haddr[2:0] == 3'b000);
      default:     align_ok_c = 1'b0;
    endcase
  end

  assign legal_c  = range_ok_c && size_ok_c && align_ok_c;
  assign accept_c = i_hsel && i_hready &&
                    (i_htrans == HTRANS_NONSEQ || i_htrans == HTRANS_SEQ);
  // ERR2 accepts like IDLE: the manager may already be driving the next transfer.
  assign decide_c = (state == SUB_IDLE) || (state == SUB_DATA) || (state == SUB_ERR2);
  assign take_c   = accept_c && decide_c;

`ifdef AHB_SUBORDINATE_RAND_WAIT_EN
  logic [15:0] lfsr;

  always_ff @(posedge i_hclk) begin
    if (i_hreset)    lfsr <= 16'hACE1;
    else if (take_c) lfsr <= lfsr_step(lfsr);
  end

  assign waits_c = CNT_W'(WAIT_STATES) + CNT_W'(lfsr[1:0]);
`else
  assign waits_c = CNT_W'(WAIT_STATES);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hready_n = 1'b1;
    hresp_n  = HRESP_OKAY;
    if (take_c) begin
      if (!legal_c) begin
        state_n = SUB_ERR1;
      end else if (waits_c != '0) begin
        state_n = SUB_WAIT;
        cnt_n   = waits_c;
      end else begin
        state_n = SUB_DATA;
      end
    end else begin
      case (state)
        SUB_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state_n = SUB_DATA;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        SUB_ERR1: state_n = SUB_ERR2;
        default:  state_n = SUB_IDLE;
      endcase
    end
    if (state_n == SUB_WAIT || state_n == SUB_ERR1) hready_n = 1'b0;
    if (state_n == SUB_ERR1 || state_n == SUB_ERR2) hresp_n  = HRESP_ERROR;
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state    <= SUB_IDLE;
      cnt      <= '0;
      o_hready <= 1'b1;
      o_hresp  <= HRESP_OKAY;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      o_hready <= hready_n;
      o_hresp  <= hresp_n;
    end
  end

  // Accepted transfer attributes for the data phase.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      word_q <= '0;
      be_q   <= '0;
    end else if (take_c) begin
      wr_q   <= legal_c && i_hwrite;
      rd_q   <= legal_c && !i_hwrite;
      word_q <= word_c;
      be_q   <= be_c;
    end
  end

  // A read issued while a write to the same word commits sees the RAM's old word.
  assign fwd_hit_c = take_c && legal_c && !i_hwrite && (state == SUB_DATA) && wr_q &&
                     (word_c == word_q);

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      fwd_q      <= 1'b0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else if (take_c) begin
      fwd_q      <= fwd_hit_c;
      fwd_be_q   <= be_q;
      fwd_data_q <= i_hwdata;
    end
  end

  assign ram_re = take_c && legal_c && !i_hwrite && !i_hreset;
  assign ram_we = (state == SUB_DATA) && wr_q && !i_hreset;

  ahb_subordinate_ram #(
    .DATA_WDT (DATA_WDT),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk   (i_hclk),
    .re    (ram_re),
    .raddr (word_c),
    .rdata (ram_rdata),
    .we    (ram_we),
    .be    (be_q),
    .waddr (word_q),
    .wdata (i_hwdata)
  );

  always_comb begin
    merged_c = ram_rdata;
    for (int unsigned k = 0; k < NB; k++) begin
      if (fwd_q && fwd_be_q[k]) merged_c[8*k +: 8] = fwd_data_q[8*k +: 8];
    end
  end

  // Read data is live during a read's WAIT/DATA cycles, otherwise the last read value.
  always_ff @(posedge i_hclk) begin
    if (i_hreset)                     hold_q <= '0;
    else if (state == SUB_DATA && rd_q) hold_q <= merged_c;
  end

  assign rd_active_c = rd_q && (state == SUB_WAIT || state == SUB_DATA);
  assign o_hrdata    = rd_active_c ? merged_c : hold_q;

endmodule

// File: tb/tb_ahb_subordinate_sram.sv
// Directed bench for ahb_subordinate_sram: three instances with 0, 2 and 3 wait states.
module tb_ahb_subordinate_sram;
  import ahb_subordinate_sram_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [3];
  logic        hsel   [3];
  logic [31:0] haddr  [3];
  t_htrans     htrans [3];
  logic        hwrite [3];
  t_hsize      hsize  [3];
  t_hburst     hburst [3];
  logic [31:0] hwdata [3];
  logic [31:0] hrdata [3];
  logic        hrdy   [3];
  t_hresp      hresp  [3];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_subordinate_sram #(
      .DATA_WDT    (32),
      .DEPTH       (1024),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .i_hclk   (clk),
      .i_hreset (rst[g]),
      .i_hsel   (hsel[g]),
      .i_haddr  (haddr[g]),
      .i_htrans (htrans[g]),
      .i_hwrite (hwrite[g]),
      .i_hsize  (hsize[g]),
      .i_hburst (hburst[g]),
      .i_hwdata (hwdata[g]),
      .i_hready (hrdy[g]),
      .o_hrdata (hrdata[g]),
      .o_hready (hrdy[g]),
      .o_hresp  (hresp[g])
    );
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    t_hsize      sz;
    logic [31:0] wd;
    logic [31:0] rd;
    t_hresp      resp;
    int          waits;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input t_hsize sz,
                     input logic [31:0] wd, input logic [31:0] rd, input t_hresp resp,
                     input int waits);
    vec_t v;
    v.wr = wr; v.addr = addr; v.sz = sz; v.wd = wd; v.rd = rd; v.resp = resp; v.waits = waits;
    vt.push_back(v);
  endtask

  task automatic bus_idle(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = HTRANS_IDLE;
    hwrite[d] = 1'b0;
  endtask

  // Single non-pipelined transfer; reports final data/resp, stall count and stall-cycle resp.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input t_hsize sz,
                      input logic [31:0] wd, output logic [31:0] rd, output t_hresp resp,
                      output t_hresp wresp, output int waits);
    int n;
    @(negedge clk);
    hsel[d] = 1'b1; haddr[d] = addr; htrans[d] = HTRANS_NONSEQ;
    hwrite[d] = wr; hsize[d] = sz; hburst[d] = HBURST_SINGLE;
    @(negedge clk);
    bus_idle(d);
    hwdata[d] = wd;
    waits = 0; wresp = HRESP_OKAY; n = 0;
    while (!hrdy[d] && n < 40) begin
      if (hresp[d] != HRESP_OKAY) wresp = hresp[d];
      waits++; n++;
      @(negedge clk);
    end
    if (n >= 40) check("xfer_timeout", 64'(n), 64'(0));
    rd   = hrdata[d];
    resp = hresp[d];
  endtask

`ifdef AHB_SUBORDINATE_RAND_WAIT_EN
  task automatic rand_test();
    logic [31:0] mdl [16];
    logic [31:0] rd, data;
    t_hresp      resp, wresp;
    int          waits, w, sz, off, wr;
    for (int i = 0; i < 16; i++) begin
      data = $urandom;
      xfer(0, 1'b1, 32'h100 + 32'(4 * i), HSIZE_WORD, data, rd, resp, wresp, waits);
      mdl[i] = data;
      check($sformatf("rw_init%0d_resp", i), resp, HRESP_OKAY);
      check($sformatf("rw_init%0d_waits", i), 64'(waits <= 3), 64'(1));
    end
    for (int i = 0; i < 84; i++) begin
      w    = $urandom_range(0, 15);
      sz   = $urandom_range(0, 2);
      off  = (sz == 0) ? $urandom_range(0, 3) : ((sz == 1) ? 2 * $urandom_range(0, 1) : 0);
      wr   = $urandom_range(0, 1);
      data = $urandom;
      xfer(0, wr[0], 32'h100 + 32'(4 * w + off), t_hsize'(3'(sz)), data, rd, resp, wresp, waits);
      check($sformatf("rnd%0d_resp", i), resp, HRESP_OKAY);
      check($sformatf("rnd%0d_waits", i), 64'(waits <= 3), 64'(1));
      if (wr != 0) begin
        for (int k = 0; k < 4; k++) begin
          if (k >= off && k < off + (1 << sz)) mdl[w][8*k +: 8] = data[8*k +: 8];
        end
      end else begin
        check($sformatf("rnd%0d_rdata", i), rd, mdl[w]);
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    t_hresp      resp, wresp;
    int          waits, issued, dn;
    logic        adv, hr;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; hsel[i] = 1'b0; haddr[i] = '0; htrans[i] = HTRANS_IDLE;
      hwrite[i] = 1'b0; hsize[i] = HSIZE_WORD; hburst[i] = HBURST_SINGLE; hwdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_hready%0d", i), hrdy[i], 1'b1);
      check($sformatf("reset_hresp%0d", i), hresp[i], HRESP_OKAY);
      check($sformatf("reset_hrdata%0d", i), hrdata[i], 32'h0);
    end

`ifdef AHB_SUBORDINATE_RAND_WAIT_EN
    rand_test();
`else
    // Single transfers on the zero-wait instance.
    add(1'b1, 32'h010, HSIZE_WORD,  32'hDEADBEEF, 32'h0,        HRESP_OKAY,  0);
    add(1'b0, 32'h010, HSIZE_WORD,  32'h0,        32'hDEADBEEF, HRESP_OKAY,  0);
    add(1'b1, 32'h010, HSIZE_WORD,  32'h11223344, 32'h0,        HRESP_OKAY,  0);
    add(1'b1, 32'h013, HSIZE_BYTE,  32'hA5FFFFFF, 32'h0,        HRESP_OKAY,  0);
    add(1'b0, 32'h010, HSIZE_WORD,  32'h0,        32'hA5223344, HRESP_OKAY,  0);
    add(1'b1, 32'h020, HSIZE_WORD,  32'h01020304, 32'h0,        HRESP_OKAY,  0);
    add(1'b1, 32'h022, HSIZE_HALF,  32'hCAFE1111, 32'h0,        HRESP_OKAY,  0);
    add(1'b0, 32'h020, HSIZE_WORD,  32'h0,        32'hCAFE0304, HRESP_OKAY,  0);
    add(1'b1, 32'hFFC, HSIZE_WORD,  32'h55AA55AA, 32'h0,        HRESP_OKAY,  0);
    add(1'b0, 32'hFFC, HSIZE_WORD,  32'h0,        32'h55AA55AA, HRESP_OKAY,  0);
    add(1'b0, 32'h1000, HSIZE_WORD, 32'h0,        32'h0,        HRESP_ERROR, 1);
    add(1'b1, 32'h001, HSIZE_HALF,  32'hFFFFFFFF, 32'h0,        HRESP_ERROR, 1);
    add(1'b1, 32'h012, HSIZE_WORD,  32'hFFFFFFFF, 32'h0,        HRESP_ERROR, 1);
    add(1'b0, 32'h010, HSIZE_DWORD, 32'h0,        32'h0,        HRESP_ERROR, 1);
    add(1'b0, 32'h010, HSIZE_WORD,  32'h0,        32'hA5223344, HRESP_OKAY,  0);
    add(1'b0, 32'h012, HSIZE_HALF,  32'h0,        32'hA5223344, HRESP_OKAY,  0);
    add(1'b0, 32'h021, HSIZE_BYTE,  32'h0,        32'hCAFE0304, HRESP_OKAY,  0);

    for (int i = 0; i < vt.size(); i++) begin
      xfer(0, vt[i].wr, vt[i].addr, vt[i].sz, vt[i].wd, rd, resp, wresp, waits);
      check($sformatf("v%0d_resp", i), resp, vt[i].resp);
      check($sformatf("v%0d_waits", i), 64'(waits), 64'(vt[i].waits));
      check($sformatf("v%0d_stall_resp", i), wresp, vt[i].resp);
      if (!vt[i].wr && vt[i].resp == HRESP_OKAY)
        check($sformatf("v%0d_rdata", i), rd, vt[i].rd);
    end

    // Back-to-back byte write then read of the same word exercises forwarding.
    xfer(0, 1'b1, 32'h030, HSIZE_WORD, 32'h11223344, rd, resp, wresp, waits);
    @(negedge clk);
    hsel[0] = 1'b1; haddr[0] = 32'h033; htrans[0] = HTRANS_NONSEQ;
    hwrite[0] = 1'b1; hsize[0] = HSIZE_BYTE;
    check("fwd_hready_a", hrdy[0], 1'b1);
    @(negedge clk);
    check("fwd_hready_w", hrdy[0], 1'b1);
    hwdata[0] = 32'hA5776655;
    haddr[0] = 32'h030; hwrite[0] = 1'b0; hsize[0] = HSIZE_WORD;
    @(negedge clk);
    bus_idle(0);
    check("fwd_hready_r", hrdy[0], 1'b1);
    check("fwd_rdata", hrdata[0], 32'hA5223344);
    @(negedge clk);
    check("fwd_rdata_hold", hrdata[0], 32'hA5223344);
    xfer(0, 1'b0, 32'h030, HSIZE_WORD, 32'h0, rd, resp, wresp, waits);
    check("fwd_ram_rdata", rd, 32'hA5223344);

    // Unselected and BUSY cycles must not stall or write.
    hwdata[0] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("nosel%0d_hready", i), hrdy[0], 1'b1);
      check($sformatf("nosel%0d_hresp", i), hresp[0], HRESP_OKAY);
      hsel[0]   = (i >= 1) ? 1'b1 : 1'b0;
      htrans[0] = (i >= 1) ? HTRANS_BUSY : HTRANS_NONSEQ;
      hwrite[0] = 1'b1; haddr[0] = 32'h010; hsize[0] = HSIZE_WORD;
    end
    @(negedge clk);
    check("nosel_last_hready", hrdy[0], 1'b1);
    bus_idle(0);
    xfer(0, 1'b0, 32'h010, HSIZE_WORD, 32'h0, rd, resp, wresp, waits);
    check("nosel_rdata", rd, 32'hA5223344);

    // INCR4 read with two wait states per beat.
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b1, 32'h020 + 32'(4 * i), HSIZE_WORD, 32'hB0000000 + 32'(i), rd, resp, wresp, waits);
      check($sformatf("ws2_fill%0d_waits", i), 64'(waits), 64'(2));
    end
    @(negedge clk);
    hsel[1] = 1'b1; haddr[1] = 32'h020; htrans[1] = HTRANS_NONSEQ;
    hwrite[1] = 1'b0; hsize[1] = HSIZE_WORD; hburst[1] = HBURST_INCR4;
    issued = 1; adv = 1'b1; dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      hr = hrdy[1];
      check($sformatf("burst_c%0d_hready", c), hr, (c % 3 == 2));
      check($sformatf("burst_c%0d_hresp", c), hresp[1], HRESP_OKAY);
      if (hr) begin
        check($sformatf("burst_beat%0d_rdata", dn), hrdata[1], 32'hB0000000 + 32'(dn));
        dn++;
      end
      if (adv) begin
        if (issued < 4) begin
          haddr[1] = 32'h020 + 32'(4 * issued); htrans[1] = HTRANS_SEQ; issued++;
        end else begin
          bus_idle(1);
        end
      end
      adv = hr;
    end
    check("burst_beats", 64'(dn), 64'(4));
    bus_idle(1);

    // Reset during a write's wait states drops the write.
    xfer(2, 1'b1, 32'h040, HSIZE_WORD, 32'h12345678, rd, resp, wresp, waits);
    check("ws3_write_waits", 64'(waits), 64'(3));
    xfer(2, 1'b0, 32'h040, HSIZE_WORD, 32'h0, rd, resp, wresp, waits);
    check("ws3_read_rdata", rd, 32'h12345678);
    @(negedge clk);
    hsel[2] = 1'b1; haddr[2] = 32'h040; htrans[2] = HTRANS_NONSEQ;
    hwrite[2] = 1'b1; hsize[2] = HSIZE_WORD;
    @(negedge clk);
    bus_idle(2);
    hwdata[2] = 32'hFFFFFFFF;
    check("rst_in_wait_hready", hrdy[2], 1'b0);
    rst[2] = 1'b1;
    @(negedge clk);
    check("rst_hready", hrdy[2], 1'b1);
    check("rst_hresp", hresp[2], HRESP_OKAY);
    check("rst_hrdata", hrdata[2], 32'h0);
    rst[2] = 1'b0;
    repeat (4) @(negedge clk);
    xfer(2, 1'b0, 32'h040, HSIZE_WORD, 32'h0, rd, resp, wresp, waits);
    check("rst_old_rdata", rd, 32'h12345678);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
